// File: rtl/apb_addr_demux.sv
// APB single-manager to NumPorts-subordinate address demultiplexer with a held select.
// Define APB_DEMUX_DECERR_EN to answer unmapped accesses from an internal PSLVERR responder.
module apb_addr_demux #(
    parameter int unsigned NumPorts  = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter logic [AddrWidth-1:0] PortBase [NumPorts] = '{default: '0},
    parameter logic [AddrWidth-1:0] PortLast [NumPorts] = '{default: '0}
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          psel_i,
    input  logic                          penable_i,
    input  logic                          pwrite_i,
    input  logic [AddrWidth-1:0]          paddr_i,
    input  logic [DataWidth-1:0]          pwdata_i,
    output logic [DataWidth-1:0]          prdata_o,
    output logic                          pready_o,
    output logic                          pslverr_o,
    output logic [NumPorts-1:0]           mst_psel_o,
    output logic [NumPorts-1:0]           mst_penable_o,
    output logic [AddrWidth-1:0]          mst_paddr_o,
    output logic [DataWidth-1:0]          mst_pwdata_o,
    output logic                          mst_pwrite_o,
    input  logic [NumPorts*DataWidth-1:0] mst_prdata_i,
    input  logic [NumPorts-1:0]           mst_pready_i,
    input  logic [NumPorts-1:0]           mst_pslverr_i,
    output logic                          decerr_o
);

    localparam int unsigned SelWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;

`ifdef APB_DEMUX_DECERR_EN
    localparam bit DecErrEn = 1'b1;
`else
    localparam bit DecErrEn = 1'b0;
`endif

    logic                setup, access;
    logic                dec_hit, dec_unmapped;
    logic [SelWidth-1:0] dec_sel;
    logic [SelWidth-1:0] sel_d, sel_q, cur_sel;
    logic                unmapped_d, unmapped_q, cur_unmapped;
    logic                route_none;

    assign setup  = psel_i & ~penable_i;
    assign access = psel_i & penable_i;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        dec_sel = '0;
        dec_hit = 1'b0;
        for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
            if (paddr_i >= PortBase[i] && paddr_i < PortLast[i]) begin
                dec_sel = SelWidth'(i);
                dec_hit = 1'b1;
            end
        end
    end

    assign dec_unmapped = ~dec_hit;

    assign sel_d      = setup ? dec_sel : sel_q;
    assign unmapped_d = setup ? dec_unmapped : unmapped_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sel_q      <= '0;
            unmapped_q <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            unmapped_q <= unmapped_d;
        end
    end

    // Setup decodes live; the access phase trusts only the registered select.
    assign cur_sel      = setup ? dec_sel : sel_q;
    assign cur_unmapped = setup ? dec_unmapped : unmapped_q;
    assign route_none   = DecErrEn & cur_unmapped;

    always_comb begin
        mst_psel_o    = '0;
        mst_penable_o = '0;
        if (psel_i && !route_none) begin
            mst_psel_o[cur_sel]    = 1'b1;
            mst_penable_o[cur_sel] = penable_i;
        end
    end

    assign mst_paddr_o  = paddr_i;
    assign mst_pwdata_o = pwdata_i;
    assign mst_pwrite_o = pwrite_i;

    always_comb begin
        prdata_o  = '0;
        pready_o  = 1'b0;
        pslverr_o = 1'b0;
        if (access) begin
            if (route_none) begin
                pready_o  = 1'b1;
                pslverr_o = 1'b1;
            end else begin
                pready_o  = mst_pready_i[sel_q];
                pslverr_o = mst_pslverr_i[sel_q];
                prdata_o  = mst_prdata_i[int'(sel_q) * int'(DataWidth) +: DataWidth];
            end
        end
    end

`ifdef APB_DEMUX_DECERR_EN
    logic decerr_q;

    // The error responder always completes in the first access cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            decerr_q <= 1'b0;
        end else begin
            decerr_q <= access & unmapped_q;
        end
    end

    assign decerr_o = decerr_q;
`else
    assign decerr_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_addr_demux.sv
// Randomized bench for apb_addr_demux against a region-table reference model.
// Expectations follow APB_DEMUX_DECERR_EN when it is defined for the build.
module tb_apb_addr_demux;

    localparam int unsigned NumPorts = 4;
    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    // Port3 overlaps the top half of port2 so the lowest-index rule is exercised.
    localparam logic [AW-1:0] Base [NumPorts] =
        '{32'h0003_0000, 32'h0003_0100, 32'h0003_0200, 32'h0003_0280};
    localparam logic [AW-1:0] Last [NumPorts] =
        '{32'h0003_0100, 32'h0003_0200, 32'h0003_0300, 32'h0003_0400};

`ifdef APB_DEMUX_DECERR_EN
    localparam bit DecErrEn = 1'b1;
`else
    localparam bit DecErrEn = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [AW-1:0]          paddr = '0;
    logic [DW-1:0]          pwdata = '0;
    logic [DW-1:0]          prdata_o;
    logic                   pready_o, pslverr_o, decerr_o, mst_pwrite_o;
    logic [NumPorts-1:0]    mst_psel_o, mst_penable_o;
    logic [AW-1:0]          mst_paddr_o;
    logic [DW-1:0]          mst_pwdata_o;
    logic [NumPorts*DW-1:0] mst_prdata = '0;
    logic [NumPorts-1:0]    mst_pready = '0, mst_pslverr = '0;

    int n_checks = 0;
    int n_fails  = 0;
    logic decerr_pending = 1'b0;
    logic decerr_exp     = 1'b0;

    apb_addr_demux #(
        .NumPorts (NumPorts),
        .AddrWidth(AW),
        .DataWidth(DW),
        .PortBase (Base),
        .PortLast (Last)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .psel_i       (psel),
        .penable_i    (penable),
        .pwrite_i     (pwrite),
        .paddr_i      (paddr),
        .pwdata_i     (pwdata),
        .prdata_o     (prdata_o),
        .pready_o     (pready_o),
        .pslverr_o    (pslverr_o),
        .mst_psel_o   (mst_psel_o),
        .mst_penable_o(mst_penable_o),
        .mst_paddr_o  (mst_paddr_o),
        .mst_pwdata_o (mst_pwdata_o),
        .mst_pwrite_o (mst_pwrite_o),
        .mst_prdata_i (mst_prdata),
        .mst_pready_i (mst_pready),
        .mst_pslverr_i(mst_pslverr),
        .decerr_o     (decerr_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Lowest-index region holding the address, or -1 when none does.
    function automatic int region_of(input logic [AW-1:0] a);
        for (int i = 0; i < int'(NumPorts); i++) begin
            if (a >= Base[i] && a < Last[i]) return i;
        end
        return -1;
    endfunction

    // Port that should carry the transfer; -1 means the internal error responder.
    function automatic int route_of(input logic [AW-1:0] a);
        int r;
        r = region_of(a);
        if (r < 0) return DecErrEn ? -1 : 0;
        return r;
    endfunction

    function automatic logic [NumPorts-1:0] onehot(input int p);
        logic [NumPorts-1:0] v;
        v = '0;
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        decerr_exp     = decerr_pending;
        decerr_pending = 1'b0;
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        check_eq("decerr", decerr_o, decerr_exp);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_psel"}, mst_psel_o, 0);
        check_eq({tag, "_penable"}, mst_penable_o, 0);
        check_eq({tag, "_pready"}, pready_o, 0);
        check_eq({tag, "_pslverr"}, pslverr_o, 0);
        check_eq({tag, "_prdata"}, prdata_o, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            psel        = 1'b0;
            penable     = 1'b0;
            mst_pready  = '0;
            mst_pslverr = '0;
            sample();
            check_quiet("idle");
        end
    endtask

    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                        input int waits, input logic err, input logic [AW-1:0] alt_addr,
                        input bit use_alt);
        int                  p;
        logic [NumPorts-1:0] oh;
        logic [DW-1:0]       data [NumPorts];
        bit                  done;
        p  = route_of(addr);
        oh = onehot(p);
        for (int i = 0; i < int'(NumPorts); i++) data[i] = $urandom;

        tick();
        psel        = 1'b1;
        penable     = 1'b0;
        pwrite      = wr;
        paddr       = addr;
        pwdata      = wdata;
        mst_pready  = '0;
        mst_pslverr = (p < 0) ? '1 : (err ? oh : ~oh);
        mst_prdata  = {data[3], data[2], data[1], data[0]};
        sample();
        check_eq("setup_psel", mst_psel_o, oh);
        check_eq("setup_penable", mst_penable_o, 0);
        check_eq("bcast_addr", mst_paddr_o, addr);
        check_eq("bcast_wdata", mst_pwdata_o, wdata);
        check_eq("bcast_write", mst_pwrite_o, wr);

        done = 1'b0;
        for (int w = 0; w <= waits && !done; w++) begin
            tick();
            penable = 1'b1;
            if (use_alt) paddr = alt_addr;
            done = (p < 0) || (w == waits);
            // Non-target ports claim ready during waits to expose misrouting.
            mst_pready = (p < 0) ? '0 : (done ? oh : ~oh);
            sample();
            check_eq("acc_psel", mst_psel_o, oh);
            check_eq("acc_penable", mst_penable_o, oh);
            check_eq("acc_pready", pready_o, done);
            if (done) begin
                check_eq("acc_prdata", prdata_o, (p < 0) ? 32'h0 : data[p]);
                check_eq("acc_pslverr", pslverr_o, (p < 0) ? 1'b1 : err);
                decerr_pending = (p < 0);
            end
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return 32'h0002_FF00 + $urandom_range(0, 32'h600);
    endfunction

    initial begin
        // Reset state
        tick();
        sample();
        check_quiet("reset");
        tick();
        rst_ni = 1'b1;
        sample();
        check_quiet("post_reset");

        // Write to port2, 3-wait read from port0, address change during access
        xfer(32'h0003_0204, 1'b1, 32'hDEAD_BEEF, 1, 1'b0, '0, 1'b0);
        xfer(32'h0003_0010, 1'b0, 32'h0, 3, 1'b0, '0, 1'b0);
        xfer(32'h0003_0020, 1'b0, 32'h0, 2, 1'b0, 32'h0003_0210, 1'b1);
        idle(1);
        // Subordinate error on port1, then unmapped access
        xfer(32'h0003_0150, 1'b1, 32'hCAFE_F00D, 0, 1'b1, '0, 1'b0);
        xfer(32'h0009_0000, 1'b0, 32'h0, 2, 1'b0, '0, 1'b0);
        idle(2);
        // Back-to-back port3 then port1
        xfer(32'h0003_0310, 1'b0, 32'h0, 1, 1'b0, '0, 1'b0);
        xfer(32'h0003_0120, 1'b0, 32'h0, 0, 1'b0, '0, 1'b0);
        // Region edges and the overlap
        xfer(32'h0003_0290, 1'b0, 32'h0, 0, 1'b0, '0, 1'b0);
        xfer(32'h0003_02FF, 1'b0, 32'h0, 0, 1'b0, '0, 1'b0);
        xfer(32'h0003_0300, 1'b0, 32'h0, 0, 1'b0, '0, 1'b0);
        xfer(32'h0003_0400, 1'b0, 32'h0, 0, 1'b0, '0, 1'b0);
        xfer(32'h0002_FFFF, 1'b0, 32'h0, 0, 1'b0, '0, 1'b0);
        xfer(32'h0003_0100, 1'b0, 32'h0, 0, 1'b0, '0, 1'b0);
        idle(1);

        // Reset in the middle of a port3 access
        tick();
        psel       = 1'b1;
        penable    = 1'b0;
        paddr      = 32'h0003_0310;
        mst_pready = '0;
        sample();
        check_eq("mid_setup_psel", mst_psel_o, 4'b1000);
        tick();
        penable = 1'b1;
        rst_ni  = 1'b0;
        sample();
        check_eq("mid_acc_penable", mst_penable_o, 4'b1000);
        check_eq("mid_acc_pready", pready_o, 0);
        tick();
        rst_ni  = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        sample();
        check_quiet("after_rst");
        // An access phase with no setup exposes the cleared select
        tick();
        psel    = 1'b1;
        penable = 1'b1;
        paddr   = 32'h0003_0310;
        sample();
        check_eq("rst_sel_psel", mst_psel_o, 4'b0001);
        check_eq("rst_sel_penable", mst_penable_o, 4'b0001);
        idle(1);

        for (int n = 0; n < 300; n++) begin
            xfer(rand_addr(), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), rand_addr(), bit'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
